// File: rtl/bg_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : bg_rom_arbiter_if
// Brief   : Bus bundle between the two ROM requesters, the ROM and the arbiter
// Revision: 1.0
// ============================================================================
interface bg_rom_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 16
);
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic [15:0]   vga_miss_cnt;
    logic          col_req;
    logic [AW-1:0] col_addr;
    logic          col_ack;
    logic [DW-1:0] col_data;
    logic          col_valid;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;

    // Environment side: both requesters plus the ROM instance
    modport master (
        output vga_req, vga_addr, col_req, col_addr, rom_dout,
        input  vga_data, vga_valid, vga_miss_cnt, col_ack, col_data, col_valid, rom_addr
    );

    modport slave (
        input  vga_req, vga_addr, col_req, col_addr, rom_dout,
        output vga_data, vga_valid, vga_miss_cnt, col_ack, col_data, col_valid, rom_addr
    );
endinterface
`default_nettype wire

// File: rtl/bg_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bg_rom_arbiter
// Brief   : VGA-priority arbiter for the background ROM with bounded collision wait
// Revision: 1.0
// ============================================================================
module bg_rom_arbiter #(
    parameter int AW       = 19,
    parameter int DW       = 16,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    bg_rom_arbiter_if.slave bus
);
    localparam int              C_WCW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int              C_PD        = ROM_LAT + 1;
    localparam logic [C_WCW-1:0] C_WAIT_LAST = C_WCW'(MAX_WAIT - 1);
    localparam logic [15:0]     C_MISS_SAT  = 16'hFFFF;

    logic [AW-1:0]    rom_addr_q,     rom_addr_d;
    logic             col_ack_q,      col_ack_d;
    logic [C_WCW-1:0] wait_cnt_q,     wait_cnt_d;
    logic [15:0]      vga_miss_cnt_q, vga_miss_cnt_d;
    logic [C_PD-1:0]  tag_vld_q,      tag_vld_d;
    logic [C_PD-1:0]  tag_col_q,      tag_col_d;
    logic [DW-1:0]    vga_data_q,     vga_data_d;
    logic             vga_valid_q,    vga_valid_d;
    logic [DW-1:0]    col_data_q,     col_data_d;
    logic             col_valid_q,    col_valid_d;

    logic w_col_elig;
    logic w_force;
    logic w_grant_vga;
    logic w_grant_col;
    logic w_drop;

    // A request sitting in its ack cycle has already been issued
    always_comb begin
        w_col_elig  = bus.col_req & ~col_ack_q;
        w_force     = w_col_elig & (wait_cnt_q == C_WAIT_LAST);
        w_grant_vga = bus.vga_req & ~w_force;
        w_grant_col = w_col_elig & ~w_grant_vga;
        w_drop      = bus.vga_req & w_force;
    end

    always_comb begin
        rom_addr_d     = rom_addr_q;
        col_ack_d      = w_grant_col;
        wait_cnt_d     = wait_cnt_q;
        vga_miss_cnt_d = vga_miss_cnt_q;
        tag_vld_d      = '0;
        tag_col_d      = '0;
        vga_data_d     = vga_data_q;
        vga_valid_d    = 1'b0;
        col_data_d     = col_data_q;
        col_valid_d    = 1'b0;

        if (w_grant_vga) begin
            rom_addr_d = bus.vga_addr;
        end else if (w_grant_col) begin
            rom_addr_d = bus.col_addr;
        end

        if (!bus.col_req || w_grant_col) begin
            wait_cnt_d = '0;
        end else if (w_col_elig) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (w_drop && (vga_miss_cnt_q != C_MISS_SAT)) begin
            vga_miss_cnt_d = vga_miss_cnt_q + 16'd1;
        end

        // Tag stage C_PD-1 lines up with the ROM output for that read
        tag_vld_d[0] = w_grant_vga | w_grant_col;
        tag_col_d[0] = w_grant_col;
        for (int i = 1; i < C_PD; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_col_d[i] = tag_col_q[i-1];
        end

        if (tag_vld_q[C_PD-1]) begin
            if (tag_col_q[C_PD-1]) begin
                col_data_d  = bus.rom_dout;
                col_valid_d = 1'b1;
            end else begin
                vga_data_d  = bus.rom_dout;
                vga_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q     <= '0;
            col_ack_q      <= 1'b0;
            wait_cnt_q     <= '0;
            vga_miss_cnt_q <= '0;
            tag_vld_q      <= '0;
            tag_col_q      <= '0;
            vga_data_q     <= '0;
            vga_valid_q    <= 1'b0;
            col_data_q     <= '0;
            col_valid_q    <= 1'b0;
        end else begin
            rom_addr_q     <= rom_addr_d;
            col_ack_q      <= col_ack_d;
            wait_cnt_q     <= wait_cnt_d;
            vga_miss_cnt_q <= vga_miss_cnt_d;
            tag_vld_q      <= tag_vld_d;
            tag_col_q      <= tag_col_d;
            vga_data_q     <= vga_data_d;
            vga_valid_q    <= vga_valid_d;
            col_data_q     <= col_data_d;
            col_valid_q    <= col_valid_d;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.col_ack      = col_ack_q;
    assign bus.vga_miss_cnt = vga_miss_cnt_q;
    assign bus.vga_data     = vga_data_q;
    assign bus.vga_valid    = vga_valid_q;
    assign bus.col_data     = col_data_q;
    assign bus.col_valid    = col_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_bg_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bg_rom_arbiter
// Brief   : Directed vector bench for bg_rom_arbiter with a 1-cycle ROM model
// Revision: 1.0
// ============================================================================
module tb_bg_rom_arbiter;
    localparam int AW = 19;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bg_rom_arbiter_if #(.AW(AW), .DW(DW)) bus();

    bg_rom_arbiter #(.AW(AW), .DW(DW), .ROM_LAT(1), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] rom_f(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    always @(posedge clk) bus.rom_dout <= rom_f(bus.rom_addr);

    typedef struct {
        logic          vreq;
        logic [AW-1:0] vaddr;
        logic          creq;
        logic [AW-1:0] caddr;
        logic [AW-1:0] e_rom;
        logic          e_ack;
        logic          e_vv;
        logic [15:0]   e_vd;
        logic          e_cv;
        logic [15:0]   e_cd;
        logic [15:0]   e_miss;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input bit vr, input int va, input bit cr, input int ca,
                                input int er, input bit ea, input bit evv, input int evd,
                                input bit ecv, input int ecd, input int em);
        vec_t v;
        v.vreq = vr;  v.vaddr = AW'(va); v.creq = cr; v.caddr = AW'(ca);
        v.e_rom = AW'(er); v.e_ack = ea; v.e_vv = evv; v.e_vd = 16'(evd);
        v.e_cv = ecv; v.e_cd = 16'(ecd); v.e_miss = 16'(em);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vga_req  = 1'b0;
        bus.vga_addr = '0;
        bus.col_req  = 1'b0;
        bus.col_addr = '0;
    endtask

    // One forced collision slot under continuous VGA traffic; returns miss count after the drop
    task automatic starve_once(input string tag, output logic [15:0] miss_after);
        miss_after = '0;
        for (int i = 0; i < 14; i++) begin
            if (i == 8) begin
                chk({tag, "_ack"}, 32'(bus.col_ack), 32'd1);
                miss_after = bus.vga_miss_cnt;
            end
            bus.vga_req  = (i <= 9);
            bus.vga_addr = AW'(700 + i);
            bus.col_req  = (i <= 8);
            bus.col_addr = AW'(4000);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        logic [15:0] m;
        idle_inputs();

        //            vr  va  cr  ca     rom  ack vv  vd       cv  cd       miss
        tbl[0]  = mk(0,   0, 1, 1000,     0, 0, 0, 0,       0, 0,       0);
        tbl[1]  = mk(0,   0, 1, 1000,  1000, 1, 0, 0,       0, 0,       0);
        tbl[2]  = mk(0,   0, 0,    0,  1000, 0, 0, 0,       0, 0,       0);
        tbl[3]  = mk(0,   0, 0,    0,  1000, 0, 0, 0,       1, 'hA64D,  0);
        tbl[4]  = mk(0,   0, 0,    0,  1000, 0, 0, 0,       0, 'hA64D,  0);
        tbl[5]  = mk(1, 100, 1, 2000,  1000, 0, 0, 0,       0, 'hA64D,  0);
        tbl[6]  = mk(0,   0, 1, 2000,   100, 0, 0, 0,       0, 'hA64D,  0);
        tbl[7]  = mk(0,   0, 1, 2000,  2000, 1, 0, 0,       0, 'hA64D,  0);
        tbl[8]  = mk(0,   0, 0,    0,  2000, 0, 1, 'hA5C1,  0, 'hA64D,  0);
        tbl[9]  = mk(0,   0, 0,    0,  2000, 0, 0, 'hA5C1,  1, 'hA275,  0);
        tbl[10] = mk(0,   0, 0,    0,  2000, 0, 0, 'hA5C1,  0, 'hA275,  0);
        tbl[11] = mk(1, 300, 0,    0,  2000, 0, 0, 'hA5C1,  0, 'hA275,  0);
        tbl[12] = mk(1, 301, 0,    0,   300, 0, 0, 'hA5C1,  0, 'hA275,  0);
        tbl[13] = mk(0,   0, 0,    0,   301, 0, 0, 'hA5C1,  0, 'hA275,  0);
        tbl[14] = mk(0,   0, 0,    0,   301, 0, 1, 'hA489,  0, 'hA275,  0);
        tbl[15] = mk(0,   0, 0,    0,   301, 0, 1, 'hA488,  0, 'hA275,  0);
        tbl[16] = mk(0,   0, 0,    0,   301, 0, 0, 'hA488,  0, 'hA275,  0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 17; n++) begin
            chk($sformatf("v%0d_rom_addr", n),  32'(bus.rom_addr),     32'(tbl[n].e_rom));
            chk($sformatf("v%0d_col_ack", n),   32'(bus.col_ack),      32'(tbl[n].e_ack));
            chk($sformatf("v%0d_vga_valid", n), 32'(bus.vga_valid),    32'(tbl[n].e_vv));
            chk($sformatf("v%0d_vga_data", n),  32'(bus.vga_data),     32'(tbl[n].e_vd));
            chk($sformatf("v%0d_col_valid", n), 32'(bus.col_valid),    32'(tbl[n].e_cv));
            chk($sformatf("v%0d_col_data", n),  32'(bus.col_data),     32'(tbl[n].e_cd));
            chk($sformatf("v%0d_miss", n),      32'(bus.vga_miss_cnt), 32'(tbl[n].e_miss));
            bus.vga_req  = tbl[n].vreq;
            bus.vga_addr = tbl[n].vaddr;
            bus.col_req  = tbl[n].creq;
            bus.col_addr = tbl[n].caddr;
            step();
        end

        // Starvation: VGA slot issued in cycle 7 is dropped for the forced collision grant
        for (int i = 0; i < 19; i++) begin
            chk($sformatf("starve%0d_ack", i), 32'(bus.col_ack), 32'(i == 8));
            chk($sformatf("starve%0d_col_valid", i), 32'(bus.col_valid), 32'(i == 10));
            if (i >= 3) begin
                chk($sformatf("starve%0d_vga_valid", i), 32'(bus.vga_valid), 32'(i != 10));
                chk($sformatf("starve%0d_vga_data", i), 32'(bus.vga_data),
                    32'(rom_f(AW'(500 + ((i == 10) ? 6 : i - 3)))));
            end else begin
                chk($sformatf("starve%0d_vga_valid", i), 32'(bus.vga_valid), 32'd0);
            end
            if (i == 10) chk("starve_col_data", 32'(bus.col_data), 32'(rom_f(AW'(3000))));
            if (i == 8)  chk("starve_rom_addr", 32'(bus.rom_addr), 32'd3000);
            if (i == 7)  chk("starve_miss_before", 32'(bus.vga_miss_cnt), 32'd0);
            if (i >= 8)  chk($sformatf("starve%0d_miss", i), 32'(bus.vga_miss_cnt), 32'd1);
            bus.vga_req  = (i <= 15);
            bus.vga_addr = AW'(500 + i);
            bus.col_req  = (i <= 8);
            bus.col_addr = AW'(3000);
            step();
        end
        idle_inputs();
        repeat (4) step();

        // Line burst of 640 reads
        nv = 0;
        for (int i = 0; i < 646; i++) begin
            if (bus.vga_valid) nv++;
            if (i >= 3 && i < 643) begin
                chk($sformatf("burst%0d_valid", i), 32'(bus.vga_valid), 32'd1);
                chk($sformatf("burst%0d_data", i), 32'(bus.vga_data), 32'(rom_f(AW'(i - 3))));
            end else begin
                chk($sformatf("burst%0d_valid", i), 32'(bus.vga_valid), 32'd0);
            end
            bus.vga_req  = (i < 640);
            bus.vga_addr = AW'(i);
            step();
        end
        chk("burst_count", 32'(nv), 32'd640);
        idle_inputs();
        repeat (3) step();

        // Reset with two VGA reads in the tag pipe and a collision grant pending
        bus.vga_req = 1'b1; bus.vga_addr = AW'(10); bus.col_req = 1'b1; bus.col_addr = AW'(12);
        step();
        bus.vga_addr = AW'(11);
        step();
        bus.vga_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_rom_addr",  32'(bus.rom_addr),     32'd0);
        chk("rst_vga_data",  32'(bus.vga_data),     32'd0);
        chk("rst_col_data",  32'(bus.col_data),     32'd0);
        chk("rst_vga_valid", 32'(bus.vga_valid),    32'd0);
        chk("rst_col_valid", 32'(bus.col_valid),    32'd0);
        chk("rst_col_ack",   32'(bus.col_ack),      32'd0);
        chk("rst_miss",      32'(bus.vga_miss_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("post_rst%0d_vga_valid", i), 32'(bus.vga_valid), 32'(i == 5));
            chk($sformatf("post_rst%0d_vga_data", i), 32'(bus.vga_data),
                (i >= 5) ? 32'(rom_f(AW'(20))) : 32'd0);
            chk($sformatf("post_rst%0d_col_valid", i), 32'(bus.col_valid), 32'd0);
            chk($sformatf("post_rst%0d_col_ack", i), 32'(bus.col_ack), 32'd0);
            bus.vga_req  = (i == 2);
            bus.vga_addr = AW'(20);
            step();
        end
        idle_inputs();

        // Miss counter: preload one below saturation, then drop twice
        force dut.vga_miss_cnt_q = 16'hFFFE;
        step();
        release dut.vga_miss_cnt_q;
        step();
        starve_once("sat1", m);
        chk("sat1_miss", 32'(m), 32'h0000FFFF);
        repeat (2) step();
        starve_once("sat2", m);
        chk("sat2_miss", 32'(m), 32'h0000FFFF);
        chk("sat_final_miss", 32'(bus.vga_miss_cnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
